// File: rtl/combo_decoder_if.sv
// Encoded-word handshake between the keypad/entry side and combo_decoder.
// master drives words and abort; slave reports readiness.
interface combo_decoder_if;
    logic       in_valid;
    logic [4:0] in_code;
    logic       in_ready;
    logic       clear;

    modport master (output in_valid, output in_code, output clear, input in_ready);
    modport slave  (input in_valid, input in_code, input clear, output in_ready);
endinterface

// File: rtl/combo_decoder.sv
// Decodes three additive-keyed 5-bit words, compares them with the stored A/B/C combination
// and drives unlock / error / lockout. Define COMBO_LOCKOUT_EN to build the failure lockout.
module combo_decoder #(
    parameter logic [4:0] KEY0        = 5'd3,
    parameter logic [4:0] KEY1        = 5'd7,
    parameter logic [4:0] KEY2        = 5'd11,
    parameter int         OPEN_CYCLES = 4,
    parameter int         MAX_FAIL    = 3,
    parameter int         LOCK_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    combo_decoder_if.slave bus,
    input  logic [4:0]     a,
    input  logic [4:0]     b,
    input  logic [4:0]     c,
    output logic [4:0]     d0,
    output logic [4:0]     d1,
    output logic [4:0]     d2,
    output logic           unlock,
    output logic           error,
    output logic           lockout,
    output logic           busy
);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        OPEN,
        FAIL
`ifdef COMBO_LOCKOUT_EN
        ,
        LOCKED
`endif
    } state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [FW-1:0] fail_cnt, fail_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [2:0]    d_we;
    logic          ready;
    logic          accept;

    function automatic logic [4:0] decode(input logic [4:0] code, input logic [4:0] key);
        return code - key;
    endfunction

    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
        return (v >= FW'(MAX_FAIL)) ? v : v + FW'(1);
    endfunction

    assign ready        = (state == IDLE) || (state == COLLECT);
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;
    assign busy         = (state != IDLE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        fail_n  = fail_cnt;
        tmr_n   = tmr;
        d_we    = 3'b000;
        case (state)
            IDLE: begin
                if (accept) begin
                    d_we    = 3'b001;
                    idx_n   = 2'd1;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                // an abort wins over a word presented in the same cycle
                if (bus.clear) begin
                    idx_n   = 2'd0;
                    state_n = IDLE;
                end else if (accept) begin
                    d_we = 3'b001 << idx;
                    if (idx == 2'd2) begin
                        idx_n   = 2'd0;
                        state_n = CHECK;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            CHECK: begin
                if ({d0, d1, d2} == {a, b, c}) begin
                    fail_n  = '0;
                    tmr_n   = TW'(OPEN_CYCLES - 1);
                    state_n = OPEN;
                end else begin
                    state_n = FAIL;
                end
            end
            OPEN: begin
                if (tmr == '0) state_n = IDLE;
                else           tmr_n   = tmr - TW'(1);
            end
            FAIL: begin
                fail_n  = sat_inc(fail_cnt);
                state_n = IDLE;
`ifdef COMBO_LOCKOUT_EN
                if (sat_inc(fail_cnt) == FW'(MAX_FAIL)) begin
                    tmr_n   = TW'(LOCK_CYCLES - 1);
                    state_n = LOCKED;
                end
`endif
            end
`ifdef COMBO_LOCKOUT_EN
            LOCKED: begin
                if (tmr == '0) begin
                    fail_n  = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            fail_cnt <= '0;
            tmr      <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            fail_cnt <= fail_n;
            tmr      <= tmr_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            if (d_we[0]) d0 <= decode(bus.in_code, KEY0);
            if (d_we[1]) d1 <= decode(bus.in_code, KEY1);
            if (d_we[2]) d2 <= decode(bus.in_code, KEY2);
        end
    end

    // outcome flags are registered off the state, so they appear one edge after entering OPEN/FAIL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unlock <= 1'b0;
            error  <= 1'b0;
        end else begin
            unlock <= (state == OPEN);
            error  <= (state == FAIL);
        end
    end

`ifdef COMBO_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lockout <= 1'b0;
        else     lockout <= (state == LOCKED);
    end
`else
    assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_combo_decoder.sv
// Scoreboard bench for combo_decoder: entries push expected outcomes, a negedge monitor pops them.
// Lockout scenarios are exercised when COMBO_LOCKOUT_EN is defined.
module tb_combo_decoder;
    localparam logic [4:0] K0 = 5'd3;
    localparam logic [4:0] K1 = 5'd7;
    localparam logic [4:0] K2 = 5'd11;
    localparam int OPENC = 4;
    localparam int MAXF  = 3;
    localparam int LOCKC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] a = 5'd30;
    logic [4:0] b = 5'd3;
    logic [4:0] c = 5'd10;
    logic [4:0] d0, d1, d2;
    logic       unlock, error, lockout, busy;

    combo_decoder_if bus();

    combo_decoder dut (
        .clk(clk), .rst(rst), .bus(bus), .a(a), .b(b), .c(c),
        .d0(d0), .d1(d1), .d2(d2),
        .unlock(unlock), .error(error), .lockout(lockout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 1 unlock, 2 error, 3 lockout
        int         cyc;
        logic [4:0] e0, e1, e2;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   fcnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic on_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check("evt_unexpected", kind, 0);
            return;
        end
        e = sb.pop_front();
        check("evt_kind", kind, e.kind);
        check("evt_cycle", cyc, e.cyc);
        if (kind == 3) begin
            check("lock_ready", bus.in_ready, 0);
        end else begin
            check("d0", d0, e.e0);
            check("d1", d1, e.e1);
            check("d2", d2, e.e2);
        end
    endtask

    initial begin : monitor
        logic pu, pe, pl;
        int   us, es, ls;
        pu = 0; pe = 0; pl = 0; us = 0; es = 0; ls = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pu = 0; pe = 0; pl = 0;
            end else begin
                if (unlock && !pu) begin on_event(1); us = cyc; end
                if (!unlock && pu) check("unlock_width", cyc - us, OPENC);
                if (error && !pe) begin on_event(2); es = cyc; end
                if (!error && pe) check("error_width", cyc - es, 1);
                if (lockout && !pl) begin on_event(3); ls = cyc; end
                if (!lockout && pl) check("lockout_width", cyc - ls, LOCKC);
                pu = unlock; pe = error; pl = lockout;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // while the block is not ready, keep presenting junk that must be ignored
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 5'($urandom);
            @(negedge clk);
            n++;
        end
        check("ready_timeout", bus.in_ready, 1);
    endtask

    task automatic entry(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2);
        exp_t e;
        int   edge_n;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_code  = c0;
        @(negedge clk);
        bus.in_code  = c1;
        @(negedge clk);
        bus.in_code  = c2;
        edge_n = cyc + 1;
        e.e0 = c0 - K0;
        e.e1 = c1 - K1;
        e.e2 = c2 - K2;
        e.cyc = edge_n + 2;
        if (e.e0 == a && e.e1 == b && e.e2 == c) begin
            fcnt = 0;
            e.kind = 1;
            sb.push_back(e);
        end else begin
            fcnt = (fcnt < MAXF) ? fcnt + 1 : MAXF;
            e.kind = 2;
            sb.push_back(e);
`ifdef COMBO_LOCKOUT_EN
            if (fcnt == MAXF) begin
                e.kind = 3;
                e.cyc  = edge_n + 3;
                sb.push_back(e);
                fcnt = 0;
            end
`endif
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_high(input string tag, input int which);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((which == 1) ? unlock : lockout) && n < 40);
        check(tag, (which == 1) ? unlock : lockout, 1);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, "_unlock"}, unlock, 0);
        check({tag, "_lockout"}, lockout, 0);
        check({tag, "_ready"}, bus.in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_d0"}, d0, 0);
        fcnt = 0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        logic [4:0] r0, r1, r2;
        bus.in_valid = 1'b0;
        bus.in_code  = 5'd0;
        bus.clear    = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", bus.in_ready, 1);
        check("rst_unlock", unlock, 0);
        check("rst_error", error, 0);
        check("rst_lockout", lockout, 0);
        check("rst_busy", busy, 0);
        check("rst_d0", d0, 0);
        check("rst_d1", d1, 0);
        check("rst_d2", d2, 0);
        @(negedge clk);
        rst = 1'b0;

        entry(5'd1, 5'd10, 5'd21);
        settle(8);
        entry(5'd1, 5'd10, 5'd22);
        settle(3);

        // abort with a simultaneous word: the word is dropped, digits stay
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_code  = 5'd1;
        @(negedge clk);
        bus.in_code  = 5'd10;
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_code  = 5'd21;
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_ready", bus.in_ready, 1);
        check("clr_d1", d1, 3);
        check("clr_d2", d2, 11);
        settle(6);
        entry(5'd1, 5'd10, 5'd21);
        settle(6);

        repeat (3) entry(5'd2, 5'd10, 5'd21);
        entry(5'd1, 5'd10, 5'd21);
        settle(8);

        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                r0 = a + K0; r1 = b + K1; r2 = c + K2;
            end else begin
                r0 = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
            end
            entry(r0, r1, r2);
        end
        settle(12);

        entry(5'd1, 5'd10, 5'd21);
        wait_high("open_seen", 1);
        pulse_reset("rst_open");
        settle(2);

`ifdef COMBO_LOCKOUT_EN
        repeat (3) entry(5'd1, 5'd11, 5'd21);
        wait_high("lock_seen", 2);
        settle(2);
        pulse_reset("rst_lock");
        entry(5'd1, 5'd11, 5'd21);
        settle(4);
`else
        entry(5'd1, 5'd11, 5'd21);
        settle(4);
`endif

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        settle(10);
        check("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
